serial_frame_receiver: RTL and testbench
========================================

Name: serial_frame_receiver

Overview:
Downstream consumer of the 8-bit shift register's serial output.
- Watches a single serial line for framed words: start bit, DATA_W data bits LSB first, optional parity bit, stop bit.
- Reassembles each word and presents it in parallel with a one-cycle valid strobe.
- Flags parity and framing errors.
- Gives the team a checked path from any shift-register serial output back to a parallel bus.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 2..16).
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial line; idles high (1).
- bit_en  input  1  sample strobe; sin is examined only on clk edges where bit_en=1.
- data_out  output  DATA_W  last correctly framed word; bit 0 is the first data bit received.
- valid  output  1  one-cycle pulse when data_out is updated.
- parity_err  output  1  one-cycle pulse, coincident with valid, when the parity bit mismatches.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; data_out=0; valid=0; parity_err=0; frame_err=0; busy=0; bit counter=0; shift buffer=0.
- Reset asserted mid-frame aborts the frame immediately. No valid or error pulse is emitted for the partial frame.
- States and transitions (evaluated only on edges with bit_en=1; with bit_en=0 all state is held):
  - IDLE: sin=0 -> DATA, counter=0. sin=1 -> stay in IDLE.
  - DATA: shift sin into the MSB of the DATA_W buffer (right shift), so the first data bit ends up in bit 0. Counter increments. When counter==DATA_W-1, go to PARITY if PARITY_EN=1, else go to STOP.
  - PARITY: capture sin as the received parity bit, then go to STOP.
  - STOP, sin=1 (good frame): data_out <= buffer; valid=1. parity_err=1 iff PARITY_EN=1 and (XOR of buffer bits XOR received parity bit) != PARITY_ODD. Go to IDLE.
  - STOP, sin=0 (bad frame): frame_err=1; valid=0; parity_err=0; data_out unchanged. Go to IDLE. The 0 just sampled is not taken as a new start bit; a fresh 0 on a later strobe is needed.
- Output timing:
  - valid, parity_err and frame_err are registered. Each is high for exactly one clk cycle, the cycle immediately after the edge that sampled the stop bit.
  - They are 0 in every other cycle, including while bit_en is held high.
- busy is registered and equals (state != IDLE).
  - Rises the cycle after the start-bit edge.
  - Falls the cycle after the stop-bit edge.
- data_out holds its value between good frames.
- Back-to-back frames: a start bit may arrive on the very next strobe after the stop bit. No idle bits are required.
- Latency: the good-frame word appears 1 clk cycle after the stop-bit sampling edge. Frame length is 1 + DATA_W + PARITY_EN + 1 strobes.
- sin changing while bit_en=0 has no effect. No glitch filtering or oversampling; sin is assumed synchronous to clk.

Test Plan:
- Config DATA_W=8, PARITY_EN=1, PARITY_ODD=0, bit_en=1 every cycle, frame 0xA5: bits 0,1,0,1,0,0,1,0,1,0(parity),1(stop).
  -> data_out=8'hA5; valid one cycle; parity_err=0; busy high 10 cycles.
- Same config, 0xA5 frame with parity bit 1.
  -> data_out=8'hA5; valid=1 and parity_err=1 in the same cycle.
- Same config, 0x3C frame with stop bit 0.
  -> frame_err one-cycle pulse; valid=0; data_out still holds previous 8'hA5; state returns to IDLE.
- Same config, frames 0x01 then 0xFE back to back with no idle bits; then 0x55 with bit_en high only every 3rd cycle.
  -> two valid pulses with data_out=8'h01 then 8'hFE; then data_out=8'h55; sin toggles between strobes ignored.
- Same config, start a frame, assert rst after 4 data bits for 1 cycle, release, then send a full 0x7E frame.
  -> all outputs 0 during reset; no pulse for the aborted frame; next frame gives data_out=8'h7E, valid=1.
- Config PARITY_EN=0, DATA_W=4, frame 0xB: bits 0,1,1,0,1,1.
  -> data_out=4'hB; valid one cycle; parity_err=0; busy high 5 cycles.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional parity, stop bit.
// Sampled only on bit_en strobes; the word and its status are presented as registered pulses.
module serial_frame_receiver #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   input  logic              bit_en,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int unsigned     CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 32'd1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   // Combined parity of the received word and the received parity bit.
   function automatic logic calc_parity(input logic [DATA_W-1:0] word, input logic rx_par);
      return (^word) ^ rx_par;
   endfunction

   logic [1:0]        state_r, state_nxt_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
   logic [DATA_W-1:0] shift_r, shift_nxt_s;
   logic              par_bit_r, par_bit_nxt_s;
   logic [DATA_W-1:0] data_r, data_nxt_s;
   logic              valid_r, valid_nxt_s;
   logic              perr_r, perr_nxt_s;
   logic              ferr_r, ferr_nxt_s;
   logic              busy_r;

   // Next-state and pulse computation; everything holds unless bit_en strobes.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      shift_nxt_s   = shift_r;
      par_bit_nxt_s = par_bit_r;
      data_nxt_s    = data_r;
      valid_nxt_s   = 1'b0;
      perr_nxt_s    = 1'b0;
      ferr_nxt_s    = 1'b0;
      if (bit_en) begin
         case (state_r)
            ST_IDLE: begin
               if (!sin) begin
                  state_nxt_s = ST_DATA;
                  cnt_nxt_s   = '0;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_DATA: begin
               shift_nxt_s = {sin, shift_r[DATA_W-1:1]};
               if (cnt_r == CNT_LAST) begin
                  cnt_nxt_s   = '0;
                  state_nxt_s = (PARITY_EN != 32'd0) ? ST_PARITY : ST_STOP;
               end else begin
                  cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
               end
            end
            ST_PARITY: begin
               par_bit_nxt_s = sin;
               state_nxt_s   = ST_STOP;
            end
            ST_STOP: begin
               // A 0 stop bit ends the frame; it is not reused as the next start bit.
               if (sin) begin
                  data_nxt_s  = shift_r;
                  valid_nxt_s = 1'b1;
                  perr_nxt_s  = (PARITY_EN != 32'd0) &&
                                (calc_parity(shift_r, par_bit_r) != (PARITY_ODD != 32'd0));
               end else begin
                  ferr_nxt_s  = 1'b1;
               end
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = '0;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State and registered outputs, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         shift_r   <= '0;
         par_bit_r <= 1'b0;
         data_r    <= '0;
         valid_r   <= 1'b0;
         perr_r    <= 1'b0;
         ferr_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         shift_r   <= shift_nxt_s;
         par_bit_r <= par_bit_nxt_s;
         data_r    <= data_nxt_s;
         valid_r   <= valid_nxt_s;
         perr_r    <= perr_nxt_s;
         ferr_r    <= ferr_nxt_s;
         busy_r    <= (state_nxt_s != ST_IDLE);
      end
   end

   assign data_out   = data_r;
   assign valid      = valid_r;
   assign parity_err = perr_r;
   assign frame_err  = ferr_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: an 8-bit even-parity instance and a 4-bit
// no-parity instance; expected events are queued as frames are driven.
module tb_serial_frame_receiver;

   typedef struct packed {
      logic       v;
      logic       pe;
      logic       fe;
      logic [7:0] d;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sin8 = 1'b1, en8 = 1'b0, sin4 = 1'b1, en4 = 1'b0;
   logic [7:0] d8;
   logic [3:0] d4;
   logic       v8, pe8, fe8, b8, v4, pe4, fe4, b4;

   ev_t        exp_q[$], obs_q[$], exp4_q[$], obs4_q[$];
   int         n_vec = 0, n_miss = 0;
   int         busy8_cnt = 0, busy4_cnt = 0;
   logic [7:0] model_d8 = 8'h00;

   serial_frame_receiver #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut8 (
      .clk(clk), .rst(rst), .sin(sin8), .bit_en(en8),
      .data_out(d8), .valid(v8), .parity_err(pe8), .frame_err(fe8), .busy(b8));

   serial_frame_receiver #(.DATA_W(4), .PARITY_EN(0), .PARITY_ODD(0)) dut4 (
      .clk(clk), .rst(rst), .sin(sin4), .bit_en(en4),
      .data_out(d4), .valid(v4), .parity_err(pe4), .frame_err(fe4), .busy(b4));

   always #5 clk = ~clk;

   // Collect every output pulse and count busy cycles, sampled away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (v8 || pe8 || fe8) obs_q.push_back(ev_t'({v8, pe8, fe8, d8}));
         if (v4 || pe4 || fe4) obs4_q.push_back(ev_t'({v4, pe4, fe4, 4'h0, d4}));
         if (b8) busy8_cnt++;
         if (b4) busy4_cnt++;
      end
   end

   task automatic drive_bit8(input logic b, input int gap);
      @(negedge clk);
      sin8 = b;
      en8  = 1'b1;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         en8  = 1'b0;
         sin8 = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic idle8(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sin8 = 1'b1;
         en8  = 1'b1;
      end
   endtask

   task automatic send8(input logic [7:0] d, input logic par, input logic stop, input int gap);
      if (stop) begin
         model_d8 = d;
         exp_q.push_back(ev_t'({1'b1, (^d) ^ par, 1'b0, d}));
      end else begin
         exp_q.push_back(ev_t'({1'b0, 1'b0, 1'b1, model_d8}));
      end
      drive_bit8(1'b0, gap);
      for (int i = 0; i < 8; i++) drive_bit8(d[i], gap);
      drive_bit8(par, gap);
      drive_bit8(stop, gap);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if ({d8, v8, pe8, fe8, b8} !== 12'h000) begin
         n_miss++;
         $display("FAIL reset8: got %h, want %h", {d8, v8, pe8, fe8, b8}, 12'h000);
      end
      n_vec++;
      if ({d4, v4, pe4, fe4, b4} !== 8'h00) begin
         n_miss++;
         $display("FAIL reset4: got %h, want %h", {d4, v4, pe4, fe4, b4}, 8'h00);
      end
      rst = 1'b0;
      idle8(2);
   endtask

   task automatic test_good_frame;
      ev_t e, o;
      busy8_cnt = 0;
      send8(8'hA5, 1'b0, 1'b1, 0);
      idle8(3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_miss++;
            $display("FAIL good_frame: got no pulse, want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_miss++;
               $display("FAIL good_frame: got %h, want %h", o, e);
            end
         end
      end
      n_vec++;
      if (obs_q.size() != 0) begin
         n_miss++;
         $display("FAIL good_frame_extra: got %0d extra pulses, want 0", obs_q.size());
         obs_q.delete();
      end
      n_vec++;
      if (busy8_cnt != 10) begin
         n_miss++;
         $display("FAIL good_frame_busy: got %0d busy cycles, want 10", busy8_cnt);
      end
   endtask

   task automatic test_parity_err;
      ev_t e, o;
      send8(8'hA5, 1'b1, 1'b1, 0);
      idle8(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_miss++;
            $display("FAIL parity_err: got no pulse, want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_miss++;
               $display("FAIL parity_err: got %h, want %h", o, e);
            end
         end
      end
   endtask

   task automatic test_frame_err;
      ev_t e, o;
      send8(8'h3C, 1'b0, 1'b0, 0);
      idle8(1);
      n_vec++;
      if (b8 !== 1'b0) begin
         n_miss++;
         $display("FAIL frame_err_idle: got busy %b, want 0", b8);
      end
      idle8(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_miss++;
            $display("FAIL frame_err: got no pulse, want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_miss++;
               $display("FAIL frame_err: got %h, want %h", o, e);
            end
         end
      end
      n_vec++;
      if (obs_q.size() != 0 || b8 !== 1'b0) begin
         n_miss++;
         $display("FAIL frame_err_after: got %0d extra pulses busy %b, want 0 and 0", obs_q.size(), b8);
         obs_q.delete();
      end
   endtask

   task automatic test_back_to_back;
      ev_t e, o;
      send8(8'h01, 1'b1, 1'b1, 0);
      send8(8'hFE, 1'b1, 1'b1, 0);
      idle8(2);
      send8(8'h55, 1'b0, 1'b1, 2);
      idle8(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_miss++;
            $display("FAIL back_to_back: got no pulse, want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_miss++;
               $display("FAIL back_to_back: got %h, want %h", o, e);
            end
         end
      end
      n_vec++;
      if (obs_q.size() != 0) begin
         n_miss++;
         $display("FAIL back_to_back_extra: got %0d extra pulses, want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_reset_abort;
      ev_t e, o;
      drive_bit8(1'b0, 0);
      for (int i = 0; i < 4; i++) drive_bit8(1'(i & 1), 0);
      @(negedge clk);
      en8 = 1'b0;
      rst = 1'b1;
      #1;
      n_vec++;
      if ({d8, v8, pe8, fe8, b8} !== 12'h000) begin
         n_miss++;
         $display("FAIL abort_in_reset: got %h, want %h", {d8, v8, pe8, fe8, b8}, 12'h000);
      end
      @(negedge clk);
      rst = 1'b0;
      model_d8 = 8'h00;
      idle8(3);
      n_vec++;
      if (obs_q.size() != 0 || b8 !== 1'b0 || d8 !== 8'h00) begin
         n_miss++;
         $display("FAIL abort_no_pulse: got %0d pulses busy %b data %h, want 0 0 00",
                  obs_q.size(), b8, d8);
         obs_q.delete();
      end
      send8(8'h7E, 1'b0, 1'b1, 0);
      idle8(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_miss++;
            $display("FAIL abort_next_frame: got no pulse, want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_miss++;
               $display("FAIL abort_next_frame: got %h, want %h", o, e);
            end
         end
      end
   endtask

   task automatic test_no_parity;
      ev_t        e, o;
      logic [5:0] bits;
      bits = 6'b110110;
      busy4_cnt = 0;
      exp4_q.push_back(ev_t'({1'b1, 1'b0, 1'b0, 8'h0B}));
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         sin4 = bits[i];
         en4  = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         sin4 = 1'b1;
         en4  = 1'b1;
      end
      while (exp4_q.size() > 0) begin
         e = exp4_q.pop_front();
         n_vec++;
         if (obs4_q.size() == 0) begin
            n_miss++;
            $display("FAIL no_parity: got no pulse, want %h", e);
         end else begin
            o = obs4_q.pop_front();
            if (o !== e) begin
               n_miss++;
               $display("FAIL no_parity: got %h, want %h", o, e);
            end
         end
      end
      n_vec++;
      if (obs4_q.size() != 0 || busy4_cnt != 5) begin
         n_miss++;
         $display("FAIL no_parity_busy: got %0d extra pulses %0d busy cycles, want 0 and 5",
                  obs4_q.size(), busy4_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_good_frame;
      test_parity_err;
      test_frame_err;
      test_back_to_back;
      test_reset_abort;
      test_no_parity;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
